// File: rtl/cut_sequencer.sv
// cut_sequencer: job sequencer for the cutting cell.
// Measures stock length with the ultrasonic ranger, divides it into equal
// segments with a restoring divider, then steps the carriage, issues cuts,
// and drives the carriage home. Sensor failures are retried up to a limit.
module cut_sequencer #(
    parameter int DIS_W      = 17,
    parameter int SLICE_W    = 5,
    parameter int STABLE_CYC = 2500,
    parameter int MAX_RETRY  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pause,
    input  logic [SLICE_W-1:0] slice_num,
    input  logic               valid,
    input  logic               fail,
    input  logic [DIS_W-1:0]   distance,
    input  logic               triggerSuc,
    output logic               trigger,
    output logic               move,
    output logic               back,
    input  logic               cut_end,
    output logic               cut,
    output logic               finish,
    output logic               error,
    output logic               busy,
    output logic [SLICE_W-1:0] cut_count
);

    localparam int GAP_W  = $clog2(STABLE_CYC + 1);
    localparam int RTY_W  = $clog2(MAX_RETRY + 1);
    localparam int DCNT_W = (DIS_W > 1) ? $clog2(DIS_W) : 1;

    localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(STABLE_CYC);
    localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RETRY);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DIS_W - 1);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_INIT_TRI = 4'd1;
    localparam logic [3:0] S_INIT_MEA = 4'd2;
    localparam logic [3:0] S_DIVIDE   = 4'd3;
    localparam logic [3:0] S_TRIGGER  = 4'd4;
    localparam logic [3:0] S_MEASURE  = 4'd5;
    localparam logic [3:0] S_CUT      = 4'd6;
    localparam logic [3:0] S_BACK_TRI = 4'd7;
    localparam logic [3:0] S_BACK     = 4'd8;
    localparam logic [3:0] S_PAUSE    = 4'd9;
    localparam logic [3:0] S_ERROR    = 4'd10;

    // Unsigned subtraction clamped at zero (carriage positions never go negative).
    function automatic logic [DIS_W-1:0] sat_sub(input logic [DIS_W-1:0] a,
                                                 input logic [DIS_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

    logic [3:0]         state, state_nxt;
    logic [3:0]         resume_st, resume_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_nxt;
    logic [RTY_W-1:0]   retry_cnt, retry_nxt;
    logic [SLICE_W-1:0] slice_lat, slice_nxt;
    logic [SLICE_W-1:0] cnt_nxt;
    logic [DIS_W-1:0]   len_q, len_nxt;
    logic [DIS_W-1:0]   loc_q, loc_nxt;
    logic [DIS_W-1:0]   seg_q, seg_nxt;
    logic [DIS_W-1:0]   div_dvd, div_dvd_nxt;
    logic [DIS_W-1:0]   div_rem, div_rem_nxt;
    logic [DIS_W-1:0]   div_quo, div_quo_nxt;
    logic [DCNT_W-1:0]  div_cnt, div_cnt_nxt;
    logic               trigger_nxt;
    logic               finish_nxt;
    logic               bad_start;

    logic [DIS_W-1:0]   divisor;
    logic [DIS_W:0]     div_trial;
    logic               div_ge;
    logic [DIS_W-1:0]   div_rem_step;
    logic [DIS_W-1:0]   tgt;
    logic               is_tri;
    logic               is_mea;

    // Datapath helpers: one restoring-division step and the next cut target.
    always_comb begin
        divisor      = DIS_W'(slice_lat);
        div_trial    = {div_rem, div_dvd[DIS_W-1]};
        div_ge       = (div_trial >= {1'b0, divisor});
        div_rem_step = div_ge ? (div_trial[DIS_W-1:0] - divisor) : div_trial[DIS_W-1:0];
        tgt          = sat_sub(loc_q, seg_q);
        is_tri       = (state == S_INIT_TRI) || (state == S_TRIGGER) || (state == S_BACK_TRI);
        is_mea       = (state == S_INIT_MEA) || (state == S_MEASURE) || (state == S_BACK);
    end

    // Next-state logic; event priority is pause, then fail, then valid, then the rest.
    always_comb begin
        state_nxt   = state;
        resume_nxt  = resume_st;
        gap_nxt     = '0;
        retry_nxt   = retry_cnt;
        slice_nxt   = slice_lat;
        cnt_nxt     = cut_count;
        len_nxt     = len_q;
        loc_nxt     = loc_q;
        seg_nxt     = seg_q;
        div_dvd_nxt = div_dvd;
        div_rem_nxt = div_rem;
        div_quo_nxt = div_quo;
        div_cnt_nxt = div_cnt;
        trigger_nxt = 1'b0;
        finish_nxt  = 1'b0;
        bad_start   = 1'b0;

        if (pause && (state != S_ERROR)) begin
            if (state == S_PAUSE) begin
                state_nxt = resume_st;
            end else begin
                state_nxt = S_PAUSE;
                // A measurement in flight is stale after a pause, so re-trigger.
                case (state)
                    S_INIT_MEA: resume_nxt = S_INIT_TRI;
                    S_MEASURE:  resume_nxt = S_TRIGGER;
                    S_BACK:     resume_nxt = S_BACK_TRI;
                    default:    resume_nxt = state;
                endcase
            end
        end else if (fail && is_mea) begin
            retry_nxt = retry_cnt + RTY_W'(1);
            if (retry_nxt == RTY_MAX) begin
                state_nxt = S_ERROR;
            end else begin
                case (state)
                    S_INIT_MEA: state_nxt = S_INIT_TRI;
                    S_MEASURE:  state_nxt = S_TRIGGER;
                    default:    state_nxt = S_BACK_TRI;
                endcase
            end
        end else if (valid && is_mea) begin
            retry_nxt = '0;
            case (state)
                S_INIT_MEA: begin
                    len_nxt     = distance;
                    loc_nxt     = distance;
                    div_dvd_nxt = distance;
                    div_rem_nxt = '0;
                    div_quo_nxt = '0;
                    div_cnt_nxt = '0;
                    state_nxt   = S_DIVIDE;
                end
                S_MEASURE: begin
                    state_nxt = (distance <= tgt) ? S_CUT : S_TRIGGER;
                end
                default: begin
                    if (distance >= len_q) begin
                        finish_nxt = 1'b1;
                        state_nxt  = S_IDLE;
                    end else begin
                        state_nxt = S_BACK_TRI;
                    end
                end
            endcase
        end else begin
            case (state)
                S_IDLE, S_ERROR: begin
                    if (start) begin
                        if (slice_num >= SLICE_W'(2)) begin
                            state_nxt = S_INIT_TRI;
                            slice_nxt = slice_num;
                            cnt_nxt   = '0;
                            retry_nxt = '0;
                        end else if (state == S_IDLE) begin
                            bad_start = 1'b1;
                        end
                    end
                end
                S_INIT_TRI, S_TRIGGER, S_BACK_TRI: begin
                    if (triggerSuc) begin
                        case (state)
                            S_INIT_TRI: state_nxt = S_INIT_MEA;
                            S_TRIGGER:  state_nxt = S_MEASURE;
                            default:    state_nxt = S_BACK;
                        endcase
                    end else begin
                        gap_nxt     = (gap_cnt == GAP_MAX) ? gap_cnt : gap_cnt + GAP_W'(1);
                        trigger_nxt = (gap_cnt == GAP_MAX);
                    end
                end
                S_DIVIDE: begin
                    div_rem_nxt = div_rem_step;
                    div_quo_nxt = {div_quo[DIS_W-2:0], div_ge};
                    div_dvd_nxt = {div_dvd[DIS_W-2:0], 1'b0};
                    div_cnt_nxt = div_cnt + DCNT_W'(1);
                    if (div_cnt == DCNT_LAST) begin
                        seg_nxt   = {div_quo[DIS_W-2:0], div_ge};
                        state_nxt = S_TRIGGER;
                    end
                end
                S_CUT: begin
                    if (cut_end) begin
                        cnt_nxt   = cut_count + SLICE_W'(1);
                        loc_nxt   = sat_sub(loc_q, seg_q);
                        state_nxt = (cnt_nxt == slice_lat - SLICE_W'(1)) ? S_BACK_TRI : S_TRIGGER;
                    end
                end
                default: ;
            endcase
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            resume_st <= S_IDLE;
            gap_cnt   <= '0;
            retry_cnt <= '0;
            slice_lat <= '0;
            cut_count <= '0;
            len_q     <= '0;
            loc_q     <= '0;
            seg_q     <= '0;
            div_dvd   <= '0;
            div_rem   <= '0;
            div_quo   <= '0;
            div_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            resume_st <= resume_nxt;
            gap_cnt   <= gap_nxt;
            retry_cnt <= retry_nxt;
            slice_lat <= slice_nxt;
            cut_count <= cnt_nxt;
            len_q     <= len_nxt;
            loc_q     <= loc_nxt;
            seg_q     <= seg_nxt;
            div_dvd   <= div_dvd_nxt;
            div_rem   <= div_rem_nxt;
            div_quo   <= div_quo_nxt;
            div_cnt   <= div_cnt_nxt;
        end
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            trigger <= 1'b0;
            move    <= 1'b0;
            back    <= 1'b0;
            cut     <= 1'b0;
            finish  <= 1'b0;
            error   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            trigger <= trigger_nxt;
            move    <= (state_nxt == S_MEASURE) || (state_nxt == S_BACK);
            back    <= (state_nxt == S_BACK);
            cut     <= (state_nxt == S_CUT);
            finish  <= finish_nxt;
            error   <= (state_nxt == S_ERROR) || bad_start;
            busy    <= (state_nxt != S_IDLE) && (state_nxt != S_ERROR);
        end
    end

endmodule

// File: tb/tb_cut_sequencer.sv
// Testbench for cut_sequencer: plays the ranger and cut controller, and checks
// outputs against a job-level model (segment = length / slices, targets by
// saturating subtraction, retry budget).
module tb_cut_sequencer;

    localparam int DIS_W     = 17;
    localparam int SLICE_W   = 5;
    localparam int GAP       = 30;
    localparam int MAX_RETRY = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               pause;
    logic [SLICE_W-1:0] slice_num;
    logic               valid;
    logic               fail;
    logic [DIS_W-1:0]   distance;
    logic               triggerSuc;
    logic               trigger;
    logic               move;
    logic               back;
    logic               cut_end;
    logic               cut;
    logic               finish;
    logic               error;
    logic               busy;
    logic [SLICE_W-1:0] cut_count;

    int n_tests = 0;
    int n_fail  = 0;

    int unsigned m_len, m_seg, m_loc, m_cc, m_slice, m_cons;

    always #5 clk = ~clk;

    cut_sequencer #(
        .DIS_W(DIS_W), .SLICE_W(SLICE_W), .STABLE_CYC(GAP), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .slice_num(slice_num),
        .valid(valid), .fail(fail), .distance(distance), .triggerSuc(triggerSuc),
        .trigger(trigger), .move(move), .back(back), .cut_end(cut_end), .cut(cut),
        .finish(finish), .error(error), .busy(busy), .cut_count(cut_count)
    );

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned m_target();
        return (m_loc > m_seg) ? m_loc - m_seg : 0;
    endfunction

    task automatic do_trigger(input string tag, input int exp_gap,
                              input logic exp_move, input logic exp_back);
        int n;
        n = 0;
        while (trigger !== 1'b1 && n < exp_gap + 200) begin
            step();
            n++;
        end
        check({tag, "_gap"}, 32'(n), 32'(exp_gap));
        triggerSuc = 1'b1;
        step();
        triggerSuc = 1'b0;
        check({tag, "_trg_off"}, 32'(trigger), 32'(0));
        check({tag, "_move"}, 32'(move), 32'(exp_move));
        check({tag, "_back"}, 32'(back), 32'(exp_back));
    endtask

    task automatic send_valid(input int unsigned d);
        distance = DIS_W'(d);
        valid    = 1'b1;
        step();
        valid    = 1'b0;
        m_cons   = 0;
    endtask

    // fail may coincide with a valid; fail must win.
    task automatic send_fail();
        distance = DIS_W'($urandom);
        valid    = 1'($urandom_range(0, 1));
        fail     = 1'b1;
        step();
        fail     = 1'b0;
        valid    = 1'b0;
        m_cons++;
    endtask

    task automatic start_job(input int unsigned slices);
        slice_num = SLICE_W'(slices);
        start     = 1'b1;
        step();
        start     = 1'b0;
        check("start_busy", 32'(busy), 32'(1));
        check("start_err", 32'(error), 32'(0));
        check("start_cc", 32'(cut_count), 32'(0));
        m_slice = slices;
        m_cc    = 0;
        m_cons  = 0;
    endtask

    task automatic init_phase(input int unsigned len, input int nf);
        do_trigger("init", GAP + 1, 1'b0, 1'b0);
        for (int i = 0; i < nf; i++) begin
            send_fail();
            check("init_fail_err", 32'(error), 32'(0));
            do_trigger("init_rt", GAP + 1, 1'b0, 1'b0);
        end
        send_valid(len);
        m_len = len;
        m_seg = len / m_slice;
        m_loc = len;
        check("init_mv", 32'(move), 32'(0));
        do_trigger("divide", DIS_W + GAP + 1, 1'b1, 1'b0);
    endtask

    task automatic nocut(input int unsigned d);
        send_valid(d);
        check("nocut_cut", 32'(cut), 32'(0));
        check("nocut_mv", 32'(move), 32'(0));
        do_trigger("meas_nc", GAP + 1, 1'b1, 1'b0);
    endtask

    task automatic do_cut(input int unsigned d, input bit pz);
        send_valid(d);
        check("cut_on", 32'(cut), 32'(1));
        check("cut_mv", 32'(move), 32'(0));
        if (pz) begin
            pause = 1'b1;
            step();
            pause = 1'b0;
            check("cut_pz_off", 32'(cut), 32'(0));
            check("cut_pz_busy", 32'(busy), 32'(1));
            repeat (3) step();
            pause = 1'b1;
            step();
            pause = 1'b0;
            check("cut_pz_resume", 32'(cut), 32'(1));
        end
        repeat ($urandom_range(0, 3)) begin
            step();
            check("cut_hold", 32'(cut), 32'(1));
        end
        cut_end = 1'b1;
        step();
        cut_end = 1'b0;
        m_cc++;
        m_loc = (m_loc > m_seg) ? m_loc - m_seg : 0;
        check("cut_drop", 32'(cut), 32'(0));
        check("cut_count", 32'(cut_count), 32'(m_cc));
        if (m_cc < m_slice - 1) do_trigger("meas", GAP + 1, 1'b1, 1'b0);
        else                    do_trigger("back_tri", GAP + 1, 1'b1, 1'b1);
    endtask

    task automatic run_cuts();
        int r;
        int unsigned t;
        while (m_cc < m_slice - 1) begin
            r = $urandom_range(0, 3);
            t = m_target();
            if (r == 0 && m_cons < MAX_RETRY - 1) begin
                send_fail();
                check("meas_fail_mv", 32'(move), 32'(0));
                check("meas_fail_err", 32'(error), 32'(0));
                do_trigger("meas_rt", GAP + 1, 1'b1, 1'b0);
            end else if (r == 1) begin
                nocut(($urandom_range(0, 1) == 1) ? t + 1 : t + 1 + $urandom_range(0, 999));
            end else begin
                do_cut(($urandom_range(0, 1) == 1) ? t : $urandom_range(0, t),
                       $urandom_range(0, 7) == 0);
            end
        end
    endtask

    task automatic back_final(input int unsigned d);
        send_valid(d);
        check("fin_pulse", 32'(finish), 32'(1));
        check("fin_busy", 32'(busy), 32'(0));
        check("fin_move", 32'(move), 32'(0));
        check("fin_back", 32'(back), 32'(0));
        check("fin_cc", 32'(cut_count), 32'(m_slice - 1));
        check("fin_err", 32'(error), 32'(0));
        step();
        check("fin_once", 32'(finish), 32'(0));
    endtask

    task automatic back_short(input int unsigned d);
        send_valid(d);
        check("back_sh_mv", 32'(move), 32'(0));
        check("back_sh_bk", 32'(back), 32'(0));
        check("back_sh_fin", 32'(finish), 32'(0));
        do_trigger("back_sh", GAP + 1, 1'b1, 1'b1);
    endtask

    task automatic run_back();
        int r;
        for (int k = 0; k < 20; k++) begin
            r = $urandom_range(0, 2);
            if (k == 19 || r == 0) begin
                back_final(m_len + $urandom_range(0, 2));
                break;
            end else if (r == 1 && m_cons < MAX_RETRY - 1) begin
                send_fail();
                check("back_fail_bk", 32'(back), 32'(0));
                do_trigger("back_rt", GAP + 1, 1'b1, 1'b1);
            end else begin
                back_short($urandom_range(0, m_len - 1));
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; slice_num = '0; valid = 1'b0;
        fail = 1'b0; distance = '0; triggerSuc = 1'b0; cut_end = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        check("rst_trigger", 32'(trigger), 32'(0));
        check("rst_move", 32'(move), 32'(0));
        check("rst_back", 32'(back), 32'(0));
        check("rst_cut", 32'(cut), 32'(0));
        check("rst_finish", 32'(finish), 32'(0));
        check("rst_error", 32'(error), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_cc", 32'(cut_count), 32'(0));

        // start with too few slices
        slice_num = SLICE_W'(1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("bad_start_err", 32'(error), 32'(1));
        check("bad_start_busy", 32'(busy), 32'(0));
        step();
        check("bad_start_err_end", 32'(error), 32'(0));
        check("bad_start_idle", 32'(busy), 32'(0));

        // directed job: 900 in 3 pieces
        start_job(3);
        init_phase(900, 0);
        nocut(650);
        do_cut(600, 1'b0);
        do_cut(300, 1'b1);
        back_short(500);
        back_final(900);

        // 1000 / 7 = 142, then reset while cutting
        start_job(7);
        init_phase(1000, 0);
        nocut(859);
        do_cut(858, 1'b0);
        nocut(717);
        send_valid(716);
        check("b7_cut", 32'(cut), 32'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_cut_cut", 32'(cut), 32'(0));
        check("rst_cut_busy", 32'(busy), 32'(0));
        check("rst_cut_cc", 32'(cut_count), 32'(0));
        check("rst_cut_move", 32'(move), 32'(0));

        // retry budget
        start_job(3);
        init_phase(900, 1);
        repeat (3) begin
            send_fail();
            do_trigger("r3_rt", GAP + 1, 1'b1, 1'b0);
        end
        check("r3_no_err", 32'(error), 32'(0));
        nocut(650);
        repeat (3) begin
            send_fail();
            do_trigger("r4_rt", GAP + 1, 1'b1, 1'b0);
        end
        send_fail();
        check("r4_err", 32'(error), 32'(1));
        check("r4_move", 32'(move), 32'(0));
        check("r4_busy", 32'(busy), 32'(0));
        repeat (5) step();
        check("r4_trig", 32'(trigger), 32'(0));
        pause = 1'b1;
        step();
        pause = 1'b0;
        check("err_pause_ign", 32'(error), 32'(1));
        check("err_pause_busy", 32'(busy), 32'(0));
        start_job(3);
        init_phase(900, 0);
        run_cuts();
        run_back();

        // pause in DIVIDE after 5 quotient bits, then pause in MEASURE
        start_job(7);
        do_trigger("init", GAP + 1, 1'b0, 1'b0);
        send_valid(1000);
        m_len = 1000; m_seg = 1000 / 7; m_loc = 1000;
        repeat (5) step();
        pause = 1'b1;
        step();
        pause = 1'b0;
        check("div_pz_busy", 32'(busy), 32'(1));
        repeat (6) step();
        check("div_pz_trig", 32'(trigger), 32'(0));
        pause = 1'b1;
        step();
        pause = 1'b0;
        do_trigger("div_rs", DIS_W - 5 + GAP + 1, 1'b1, 1'b0);
        pause = 1'b1;
        step();
        pause = 1'b0;
        check("meas_pz_move", 32'(move), 32'(0));
        check("meas_pz_busy", 32'(busy), 32'(1));
        repeat (4) step();
        check("meas_pz_trig", 32'(trigger), 32'(0));
        pause = 1'b1;
        step();
        pause = 1'b0;
        check("meas_rs_move", 32'(move), 32'(0));
        do_trigger("meas_rs", GAP + 1, 1'b1, 1'b0);
        nocut(m_target() + 1);
        do_cut(m_target(), 1'b0);
        run_cuts();
        run_back();

        // randomized jobs
        repeat (4) begin
            start_job($urandom_range(2, 12));
            init_phase($urandom_range(100, 100000), $urandom_range(0, 3));
            run_cuts();
            run_back();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
